// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port memory between instruction fetch and load/store.
// Load/store wins contention unless fetch has been denied STARVE_MAX times in a row.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  starve_cnt
);

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_IF    = 2'd1;
  localparam logic [1:0] OWN_LS_RD = 2'd2;
  localparam logic [1:0] OWN_LS_WR = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  logic [1:0] owner_q, owner_d;
  logic       if_win_s, ls_win_s;

  // Grant decision; gated by rst_n so nothing is granted while in reset.
  always_comb begin
    if_win_s = 1'b0;
    ls_win_s = 1'b0;
    if (rst_n == 1'b0) begin
      if_win_s = 1'b0;
      ls_win_s = 1'b0;
    end else if (if_req && (!ls_req || (starve_q == STARVE_LIM))) begin
      if_win_s = 1'b1;
    end else if (ls_req) begin
      ls_win_s = 1'b1;
    end else begin
      if_win_s = 1'b0;
      ls_win_s = 1'b0;
    end
  end

  assign if_gnt     = if_win_s;
  assign ls_gnt     = ls_win_s;
  assign mem_en     = if_win_s | ls_win_s;
  assign mem_we     = ls_win_s & ls_we;
  assign mem_addr   = if_win_s ? if_addr[31:2] : (ls_win_s ? ls_addr[31:2] : 30'd0);
  assign mem_wdata  = ls_win_s ? ls_wdata : 32'd0;
  assign starve_cnt = starve_q;

  // Next starvation count and response owner.
  always_comb begin
    starve_d = starve_q;
    owner_d  = OWN_NONE;
    if (if_win_s) begin
      starve_d = 4'd0;
    end else if (if_req && ls_win_s) begin
      starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
    end else if (!if_req) begin
      starve_d = 4'd0;
    end else begin
      starve_d = starve_q;
    end
    if (if_win_s) begin
      owner_d = OWN_IF;
    end else if (ls_win_s) begin
      owner_d = ls_we ? OWN_LS_WR : OWN_LS_RD;
    end else begin
      owner_d = OWN_NONE;
    end
  end

  // State registers; an async reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
      owner_q  <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  // Response routing: only the owner of last cycle's grant sees memory data.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = 32'd0;
    ls_rvalid = 1'b0;
    ls_rdata  = 32'd0;
    case (owner_q)
      OWN_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      OWN_LS_RD: begin
        ls_rvalid = 1'b1;
        ls_rdata  = mem_rdata;
      end
      OWN_LS_WR: begin
        ls_rvalid = 1'b1;
        ls_rdata  = 32'd0;
      end
      default: begin
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter: two instances (STARVE_MAX 4 and 1) share
// request stimulus and are compared against a behavioural arbitration and memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [31:0] mem_rdata0, mem_rdata1;

  logic        if_gnt0, if_rvalid0, ls_gnt0, ls_rvalid0, mem_en0, mem_we0;
  logic [31:0] if_rdata0, ls_rdata0, mem_wdata0;
  logic [29:0] mem_addr0;
  logic [3:0]  starve_cnt0;

  logic        if_gnt1, if_rvalid1, ls_gnt1, ls_rvalid1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, ls_rdata1, mem_wdata1;
  logic [29:0] mem_addr1;
  logic [3:0]  starve_cnt1;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt0), .if_rvalid(if_rvalid0), .if_rdata(if_rdata0),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt0), .ls_rvalid(ls_rvalid0), .ls_rdata(ls_rdata0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .starve_cnt(starve_cnt0)
  );

  mem_arbiter #(.STARVE_MAX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt1), .ls_rvalid(ls_rvalid1), .ls_rdata(ls_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .starve_cnt(starve_cnt1)
  );

  int total = 0;
  int bad   = 0;

  // Environment memory (driven by what the DUT actually issues) and model memory (driven by the model).
  logic [31:0] env_mem [logic [29:0]];
  logic [31:0] mdl_mem [logic [29:0]];

  // Model state: response owner (0 none, 1 IF, 2 LS load, 3 LS store), pending word address, starvation counts.
  int          own0, own1, cnt0, cnt1;
  logic [29:0] pend0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [31:0] env_read(input logic [29:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [29:0] a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return init_word(a);
  endfunction

  // Starvation rule: fetch granted clears; fetch waiting behind LS counts up to the limit; no fetch request clears.
  function automatic int next_cnt(input int c, input int lim, input logic ifr, input logic gi, input logic gl);
    if (gi) return 0;
    if (ifr && gl) return (c < lim) ? c + 1 : lim;
    if (!ifr) return 0;
    return c;
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance model, then memory responds.
  task automatic do_cycle(input logic ifr, input logic [31:0] ifa, input logic lsr, input logic lswe,
                          input logic [31:0] lsa, input logic [31:0] lswd);
    logic        eg_if0, eg_ls0, eg_if1, eg_ls1;
    logic [29:0] ea;
    logic [31:0] ewd, exp_rd;
    logic        cap_en, cap_we;
    logic [29:0] cap_a;
    logic [31:0] cap_wd;
    if_req   = ifr;
    if_addr  = ifa;
    ls_req   = lsr;
    ls_we    = lswe;
    ls_addr  = lsa;
    ls_wdata = lswd;
    @(negedge clk);
    eg_if0 = ifr && (!lsr || cnt0 == 4);
    eg_ls0 = lsr && !eg_if0;
    eg_if1 = ifr && (!lsr || cnt1 == 1);
    eg_ls1 = lsr && !eg_if1;
    ea     = eg_if0 ? ifa[31:2] : (eg_ls0 ? lsa[31:2] : 30'd0);
    ewd    = eg_ls0 ? lswd : 32'd0;
    exp_rd = (own0 == 1 || own0 == 2) ? mdl_read(pend0) : 32'd0;
    chk("if_gnt",    {31'd0, if_gnt0},    {31'd0, eg_if0});
    chk("ls_gnt",    {31'd0, ls_gnt0},    {31'd0, eg_ls0});
    chk("mem_en",    {31'd0, mem_en0},    {31'd0, eg_if0 | eg_ls0});
    chk("mem_we",    {31'd0, mem_we0},    {31'd0, eg_ls0 & lswe});
    chk("mem_addr",  {2'd0, mem_addr0},   {2'd0, ea});
    chk("mem_wdata", mem_wdata0,          ewd);
    chk("if_rvalid", {31'd0, if_rvalid0}, (own0 == 1) ? 32'd1 : 32'd0);
    chk("if_rdata",  if_rdata0,           (own0 == 1) ? exp_rd : 32'd0);
    chk("ls_rvalid", {31'd0, ls_rvalid0}, (own0 >= 2) ? 32'd1 : 32'd0);
    chk("ls_rdata",  ls_rdata0,           (own0 == 2) ? exp_rd : 32'd0);
    chk("starve",    {28'd0, starve_cnt0}, 32'(cnt0));
    chk("m1_if_gnt", {31'd0, if_gnt1},    {31'd0, eg_if1});
    chk("m1_ls_gnt", {31'd0, ls_gnt1},    {31'd0, eg_ls1});
    chk("m1_starve", {28'd0, starve_cnt1}, 32'(cnt1));
    chk("m1_if_rvalid", {31'd0, if_rvalid1}, (own1 == 1) ? 32'd1 : 32'd0);
    chk("m1_ls_rvalid", {31'd0, ls_rvalid1}, (own1 >= 2) ? 32'd1 : 32'd0);
    cap_en = mem_en0;
    cap_we = mem_we0;
    cap_a  = mem_addr0;
    cap_wd = mem_wdata0;
    own0  = eg_if0 ? 1 : (eg_ls0 ? (lswe ? 3 : 2) : 0);
    own1  = eg_if1 ? 1 : (eg_ls1 ? (lswe ? 3 : 2) : 0);
    pend0 = ea;
    if (eg_ls0 && lswe) mdl_mem[ea] = lswd;
    cnt0 = next_cnt(cnt0, 4, ifr, eg_if0, eg_ls0);
    cnt1 = next_cnt(cnt1, 1, ifr, eg_if1, eg_ls1);
    @(posedge clk);
    #1;
    if (cap_en && cap_we) env_mem[cap_a] = cap_wd;
    mem_rdata0 = (cap_en && !cap_we) ? env_read(cap_a) : $urandom();
    mem_rdata1 = $urandom();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_if_gnt"},    {31'd0, if_gnt0},    32'd0);
    chk({tag, "_ls_gnt"},    {31'd0, ls_gnt0},    32'd0);
    chk({tag, "_if_rvalid"}, {31'd0, if_rvalid0}, 32'd0);
    chk({tag, "_ls_rvalid"}, {31'd0, ls_rvalid0}, 32'd0);
    chk({tag, "_if_rdata"},  if_rdata0,           32'd0);
    chk({tag, "_ls_rdata"},  ls_rdata0,           32'd0);
    chk({tag, "_mem_en"},    {31'd0, mem_en0},    32'd0);
    chk({tag, "_mem_we"},    {31'd0, mem_we0},    32'd0);
    chk({tag, "_starve"},    {28'd0, starve_cnt0}, 32'd0);
    chk({tag, "_m1_if_gnt"}, {31'd0, if_gnt1},    32'd0);
    chk({tag, "_m1_ls_gnt"}, {31'd0, ls_gnt1},    32'd0);
  endtask

  initial begin
    own0 = 0; own1 = 0; cnt0 = 0; cnt1 = 0; pend0 = 30'd0;
    env_mem[30'h4] = 32'h0050_0093;
    mdl_mem[30'h4] = 32'h0050_0093;
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b1; ls_we = 1'b1;
    ls_addr = 32'h100; ls_wdata = 32'h1234_5678;
    mem_rdata0 = 32'hFFFF_FFFF; mem_rdata1 = 32'hFFFF_FFFF;
    #2;
    chk_zero("reset");
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle after release, then fetch-only scenario.
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Store then load from the same address.
    do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Both requesters held high: starvation on instance 0, saturation at 1 on instance 1.
    for (int i = 0; i < 12; i++) do_cycle(1'b1, 32'h204, 1'b1, 1'b0, 32'h300, 32'h0);
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Alternating single requesters, misaligned addresses.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) do_cycle(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0, 32'h0, 32'h0);
      else            do_cycle(1'b0, 32'h0, 1'b1, 1'($urandom_range(0, 1)), 32'h80 + 32'(i), $urandom());
    end

    // Reset in the cycle after a fetch grant: response must be dropped.
    do_cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    if_req = 1'b1; ls_req = 1'b1; mem_rdata0 = 32'hCAFE_F00D;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    chk_zero("midrst_hold");
    @(posedge clk);
    #1;
    if_req = 1'b0; ls_req = 1'b0;
    rst_n = 1'b1;
    own0 = 0; own1 = 0; cnt0 = 0; cnt1 = 0;
    do_cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Randomized traffic over a small address window to force reuse.
    for (int i = 0; i < 400; i++) begin
      do_cycle(1'($urandom_range(0, 3) != 0),
               ($urandom_range(0, 15) << 2) | ($urandom() & 32'h3),
               1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) << 2) | ($urandom() & 32'h3),
               $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, the number of consecutive fetch-denied cycles before fetch is forced to win (legal 1..15).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_req  input  1  instruction-fetch request.
REQ-005 SHALL have port if_addr  input  32  fetch byte address.
REQ-006 SHALL have port if_gnt  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port if_rvalid  output  1  fetch read data valid.
REQ-008 SHALL have port if_rdata  output  32  fetch read data.
REQ-009 SHALL have port ls_req  input  1  load/store request.
REQ-010 SHALL have port ls_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port ls_addr  input  32  load/store byte address.
REQ-012 SHALL have port ls_wdata  input  32  store data.
REQ-013 SHALL have port ls_gnt  output  1  load/store request accepted this cycle.
REQ-014 SHALL have port ls_rvalid  output  1  load data valid, or store acknowledge.
REQ-015 SHALL have port ls_rdata  output  32  load data; 0 for a store acknowledge.
REQ-016 SHALL have port mem_en  output  1  shared single-port memory enable.
REQ-017 SHALL have port mem_we  output  1  shared memory write enable.
REQ-018 SHALL have port mem_addr  output  30  word address, equal to the selected byte address bits [31:2].
REQ-019 SHALL have port mem_wdata  output  32  memory write data.
REQ-020 SHALL have port mem_rdata  input  32  memory read data, valid one cycle after mem_en.
REQ-021 SHALL have port starve_cnt  output  4  current starvation count, for debug.

Function
REQ-022 SHALL grant at most one requester per cycle.
REQ-023 SHALL generate if_gnt and ls_gnt combinationally in the same cycle as the request.
REQ-024 SHALL grant LS by default when both if_req and ls_req are high.
REQ-025 SHALL grant IF when both are high and starve_cnt == STARVE_MAX.
REQ-026 SHALL grant the sole requester when only one request is high.
REQ-027 SHALL drive mem_en = if_gnt | ls_gnt.
REQ-028 SHALL drive mem_we = ls_gnt & ls_we.
REQ-029 SHALL drive mem_addr and mem_wdata from the granted requester; when idle, mem_addr and mem_wdata SHALL be 0.
REQ-030 SHALL update starve_cnt each cycle with these priorities: IF granted -> clear; otherwise if_req high and LS granted -> increment, saturating at STARVE_MAX; otherwise if_req low -> clear.
REQ-031 SHALL register the owner of each grant (NONE, IF, LS_RD or LS_WR) in an owner_q state register.
REQ-032 SHALL assert the matching rvalid for exactly one cycle, in the cycle after the grant.
REQ-033 SHALL route mem_rdata to if_rdata when owner_q = IF, and to ls_rdata when owner_q = LS_RD.
REQ-034 SHALL drive ls_rdata = 0 when owner_q = LS_WR.
REQ-035 SHALL hold any rdata bus not selected this cycle at 0.
REQ-036 SHALL sustain back-to-back grants every cycle with no bubble, giving 1-cycle latency and a throughput of 1 access per cycle.
REQ-037 SHALL ignore address bits [1:0]; misaligned requests get no error response.
REQ-038 SHALL ignore ls_we and ls_wdata when ls_req is low.
REQ-039 SHALL, for a request not granted, leave it to the requester to hold the request and arguments stable until granted.
REQ-040 SHALL treat a request dropped before grant as never having been made.

Reset
REQ-041 SHALL, while rst_n is low, force owner_q = NONE, starve_cnt = 0, all gnt and rvalid outputs = 0, all rdata outputs = 0, and mem_en = mem_we = 0, independent of clk.
REQ-042 SHALL discard, without asserting rvalid, a response pending when reset asserts mid-transaction.
REQ-043 SHALL grant nothing in the first rising edge after rst_n deasserts unless a request is present at that edge.

Verification
REQ-044 Scenario, IF only: if_req=1, if_addr=0x0000_0010, mem_rdata=0x0050_0093 next cycle -> if_gnt=1 and mem_addr=0x4 at cycle 0; if_rvalid=1 and if_rdata=0x0050_0093 at cycle 1.
REQ-045 Scenario, store then load: ls_req/ls_we=1, ls_addr=0x100, ls_wdata=0xDEAD_BEEF, followed by a load from 0x100 -> mem_we=1 and mem_addr=0x40 for the store; ls_rvalid=1 with ls_rdata=0 in the cycle after the store; ls_rvalid=1 with ls_rdata=0xDEAD_BEEF in the cycle after the load.
REQ-046 Scenario, starvation: both requests held high continuously with STARVE_MAX=4 -> LS granted for cycles 0-3, IF granted at cycle 4, starve_cnt sequence 0,1,2,3,4,0, after which the pattern repeats.
REQ-047 Scenario, alternation: IF and LS requests alternate every cycle -> grants alternate with no bubbles, each rvalid arrives exactly one cycle after its grant, and no data crosses between requesters.
REQ-048 Scenario, reset mid-transaction: rst_n pulled low in the cycle after an IF grant -> if_rvalid stays 0 and all outputs read 0 immediately; first grant after release matches REQ-044.
REQ-049 Scenario, saturation: STARVE_MAX=1, both requests held high -> grants alternate LS, IF, LS, IF and starve_cnt never exceeds 1.
